// File: rtl/mult_pkg.sv
// Shared constants for the sequential multiplier: FSM state encodings.
package mult_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

endpackage : mult_pkg

// File: rtl/full_add_n_bit.sv
// N-bit ripple-style full adder with carry in and carry out.
module full_add_n_bit #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    // Single wide add; the carry lands in the extra top bit.
    assign {c_out, sum} = (N+1)'(a) + (N+1)'(b) + (N+1)'(c_in);

endmodule : full_add_n_bit

// File: rtl/mult_seq_n.sv
// Radix-2 shift-add sequential multiplier, unsigned or two's-complement,
// one multiplier bit per cycle, sign applied to the magnitude product.
module mult_seq_n
    import mult_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int unsigned CNT_W = $clog2(N);
    localparam int unsigned PW    = 2 * N;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [N-1:0]       mcand;
    logic               neg;
    logic [PW-1:0]      acc;

    logic [N-1:0]       add_sum;
    logic               add_co;
    logic [PW-1:0]      acc_step_c;
    logic               last_c;
    logic [N-1:0]       a_mag_c;
    logic [N-1:0]       b_mag_c;

    // Accumulation adder: upper half of the accumulator plus multiplicand magnitude.
    full_add_n_bit #(.N(N)) u_add (
        .a     (acc[PW-1:N]),
        .b     (mcand),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (add_co)
    );

    // Operand magnitudes; -2^(N-1) maps to 2^(N-1), which still fits in N bits.
    always_comb begin
        a_mag_c = a;
        b_mag_c = b;
        if (signed_mode && a[N-1]) a_mag_c = ~a + N'(1);
        if (signed_mode && b[N-1]) b_mag_c = ~b + N'(1);
    end

    // One shift-add step: conditionally add into the upper half, then shift right.
    always_comb begin
        acc_step_c = {1'b0, acc[PW-1:1]};
        if (acc[0]) acc_step_c = {add_co, add_sum, acc[N-1:1]};
        last_c = (cnt == CNT_W'(N - 1));
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)  state_nxt = ST_RUN;
            ST_RUN:  if (last_c) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Datapath, product register and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            mcand <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            p     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
            done <= (state_nxt == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand <= a_mag_c;
                        neg   <= signed_mode & (a[N-1] ^ b[N-1]);
                        acc   <= {N'(0), b_mag_c};
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    acc <= acc_step_c;
                    cnt <= last_c ? '0 : cnt + CNT_W'(1);
                    if (last_c) p <= neg ? (~acc_step_c + PW'(1)) : acc_step_c;
                end
                default: ;
            endcase
        end
    end

endmodule : mult_seq_n
